// File: rtl/ntt_controller.sv
// Stage/address sequencer for one NTT or INTT pass on ntt_processor.
// Optional NTT_CTRL_PERF_EN adds a saturating cycle_count output for the busy interval.
module ntt_controller #(
  parameter int LOG_CORE_COUNT = 5,
  parameter int LOG_N          = 14,
  parameter int ADDR_W         = 9,
  parameter int PIPE_LAT       = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode_in,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        mode,
  output logic [3:0]        log_m,
  output logic [3:0]        log_t,
  output logic [9:0]        i,
  output logic [ADDR_W-1:0] upper_read_address,
  output logic [ADDR_W-1:0] lower_read_address,
  output logic              write_enable
`ifdef NTT_CTRL_PERF_EN
  ,
  output logic [31:0]       cycle_count
`endif
);

  localparam int DRW = $clog2(PIPE_LAT + 1);

  if (LOG_N < 1 || LOG_N > 15 || PIPE_LAT < 1 || ADDR_W < 1 || LOG_CORE_COUNT < 0) begin : g_bad_param
    $error("ntt_controller: unsupported parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_NEXT,
    S_DONE
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   cnt_q;
  logic [DRW-1:0]      drain_q;
  logic [PIPE_LAT-1:0] sr_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;
  logic [1:0]          mode_q;
  logic [3:0]          log_m_q;
  logic [3:0]          log_t_q;
  logic [9:0]          i_q;
  logic [ADDR_W-1:0]   addr_q;

  logic                mode_ok;
  logic                accept;
  logic                rd_valid;
  logic                last_stage;
  logic [15:0]         stage_base;
  logic [ADDR_W-1:0]   cnt_shift;
  logic [9:0]          i_d;

  assign mode_ok    = (mode_in == 2'b01) || (mode_in == 2'b10);
  assign accept     = (state_q == S_IDLE) && start && mode_ok;
  assign rd_valid   = (state_q == S_READ);
  assign last_stage = (mode_q == 2'b01) ? (log_m_q == 4'(LOG_N - 1)) : (log_m_q == 4'd0);

  // Twiddle index: 2^log_m plus the butterfly group within the stage.
  assign stage_base = 16'd1 << log_m_q;
  assign cnt_shift  = cnt_q >> log_t_q;
  assign i_d        = 10'(stage_base + 16'(cnt_shift));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      drain_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      mode_q  <= 2'b00;
      log_m_q <= 4'd0;
      log_t_q <= 4'd0;
      i_q     <= 10'd0;
      addr_q  <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (mode_ok) begin
              mode_q  <= mode_in;
              busy_q  <= 1'b1;
              cnt_q   <= '0;
              log_m_q <= (mode_in == 2'b01) ? 4'd0 : 4'(LOG_N - 1);
              log_t_q <= (mode_in == 2'b01) ? 4'(LOG_N - 1) : 4'd0;
              state_q <= S_READ;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_READ: begin
          addr_q <= cnt_q;
          i_q    <= i_d;
          if (cnt_q == '1) begin
            drain_q <= '0;
            state_q <= S_DRAIN;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DRAIN: begin
          if (drain_q == DRW'(PIPE_LAT - 1)) begin
            state_q <= last_stage ? S_DONE : S_NEXT;
          end else begin
            drain_q <= drain_q + 1'b1;
          end
        end
        S_NEXT: begin
          if (mode_q == 2'b01) begin
            log_m_q <= log_m_q + 4'd1;
            log_t_q <= log_t_q - 4'd1;
          end else begin
            log_m_q <= log_m_q - 4'd1;
            log_t_q <= log_t_q + 4'd1;
          end
          cnt_q   <= '0;
          state_q <= S_READ;
        end
        S_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          mode_q  <= 2'b00;
          log_m_q <= 4'd0;
          log_t_q <= 4'd0;
          i_q     <= 10'd0;
          addr_q  <= '0;
          cnt_q   <= '0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Write-back strobe trails the read issue by the processor pipeline latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q[0] <= rd_valid;
      for (int k = 1; k < PIPE_LAT; k++) begin
        sr_q[k] <= sr_q[k-1];
      end
    end
  end

`ifdef NTT_CTRL_PERF_EN
  logic [31:0] cyc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q <= 32'd0;
    end else if (accept) begin
      cyc_q <= 32'd0;
    end else if (busy_q && (cyc_q != 32'hFFFF_FFFF)) begin
      cyc_q <= cyc_q + 32'd1;
    end
  end

  assign cycle_count = cyc_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

  assign busy               = busy_q;
  assign done               = done_q;
  assign err                = err_q;
  assign mode               = mode_q;
  assign log_m              = log_m_q;
  assign log_t              = log_t_q;
  assign i                  = i_q;
  assign upper_read_address = addr_q;
  assign lower_read_address = addr_q;
  assign write_enable       = sr_q[PIPE_LAT-1];

endmodule

// File: tb/tb_ntt_controller.sv
// Directed bench for ntt_controller with LOG_N=3, ADDR_W=2, PIPE_LAT=2 (pass length 21 cycles).
module tb_ntt_controller;

  localparam int LOG_N    = 3;
  localparam int ADDR_W   = 2;
  localparam int PIPE_LAT = 2;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [1:0]        mode_in;
  logic              busy;
  logic              done;
  logic              err;
  logic [1:0]        mode;
  logic [3:0]        log_m;
  logic [3:0]        log_t;
  logic [9:0]        i;
  logic [ADDR_W-1:0] upper_read_address;
  logic [ADDR_W-1:0] lower_read_address;
  logic              write_enable;
`ifdef NTT_CTRL_PERF_EN
  logic [31:0]       cycle_count;
`endif

  int checks = 0;
  int errors = 0;

  ntt_controller #(
    .LOG_CORE_COUNT(5),
    .LOG_N(LOG_N),
    .ADDR_W(ADDR_W),
    .PIPE_LAT(PIPE_LAT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .mode_in(mode_in),
    .busy(busy),
    .done(done),
    .err(err),
    .mode(mode),
    .log_m(log_m),
    .log_t(log_t),
    .i(i),
    .upper_read_address(upper_read_address),
    .lower_read_address(lower_read_address),
    .write_enable(write_enable)
`ifdef NTT_CTRL_PERF_EN
    ,
    .cycle_count(cycle_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]        mode_in;
    logic              restart;
    int                exp_len;
    logic [1:0]        exp_mode;
    logic [2:0][3:0]   exp_lm;
    logic [2:0][3:0]   exp_lt;
    logic [11:0][9:0]  exp_i;
    int                exp_we;
  } pass_t;

  pass_t tbl[3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_busy"}, 32'(busy), 32'd0);
    chk({name, "_done_err"}, {30'd0, done, err}, 32'd0);
    chk({name, "_mode_logm_logt"}, {22'd0, mode, log_m, log_t}, 32'd0);
    chk({name, "_i_addr_we"}, {17'd0, i, upper_read_address, lower_read_address, write_enable}, 32'd0);
  endtask

  // Cycle c is sampled at the falling edge after the c-th rising edge past the accept edge.
  task automatic run_pass(input pass_t p, input string tag);
    int c;
    int we_cnt;
    int len;
    int r;
    @(negedge clk);
    start   = 1'b1;
    mode_in = p.mode_in;
    @(posedge clk);
    @(negedge clk);
    start   = 1'b0;
    mode_in = 2'b00;
    c = 0;
    we_cnt = 0;
    len = -1;
    chk({tag, "_busy_c0"}, 32'(busy), 32'd1);
`ifdef NTT_CTRL_PERF_EN
    chk({tag, "_cyc_clear"}, cycle_count, 32'd0);
`endif
    while (c < 40) begin
      if (write_enable) we_cnt++;
      if (done) begin
        len = c;
        break;
      end
      if (c < 21) begin
        chk($sformatf("%s_mode_c%0d", tag, c), 32'(mode), 32'(p.exp_mode));
        if (c % 7 == 3) begin
          chk($sformatf("%s_log_m_s%0d", tag, c / 7), 32'(log_m), 32'(p.exp_lm[c/7]));
          chk($sformatf("%s_log_t_s%0d", tag, c / 7), 32'(log_t), 32'(p.exp_lt[c/7]));
        end
        if (c >= 1 && ((c - 1) % 7) < 4) begin
          r = ((c - 1) / 7) * 4 + ((c - 1) % 7);
          chk($sformatf("%s_uaddr_r%0d", tag, r), 32'(upper_read_address), 32'((c - 1) % 7));
          chk($sformatf("%s_laddr_r%0d", tag, r), 32'(lower_read_address), 32'((c - 1) % 7));
          chk($sformatf("%s_i_r%0d", tag, r), 32'(i), 32'(p.exp_i[r]));
        end
      end
      if (p.restart) begin
        if (c == 5) begin
          start   = 1'b1;
          mode_in = 2'b10;
        end else if (c == 6) begin
          chk({tag, "_busy_start_no_err"}, 32'(err), 32'd0);
          start   = 1'b0;
          mode_in = 2'b00;
        end
      end
      @(negedge clk);
      c++;
    end
    chk({tag, "_len"}, 32'(len), 32'(p.exp_len));
    chk({tag, "_we_count"}, 32'(we_cnt), 32'(p.exp_we));
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
`ifdef NTT_CTRL_PERF_EN
    chk({tag, "_cyc_final"}, cycle_count, 32'd21);
`endif
    @(negedge clk);
    chk({tag, "_done_pulse_end"}, 32'(done), 32'd0);
    chk({tag, "_idle_mode_logm"}, {26'd0, mode, log_m}, 32'd0);
`ifdef NTT_CTRL_PERF_EN
    chk({tag, "_cyc_hold"}, cycle_count, 32'd21);
`endif
  endtask

  initial begin
    int dcount;
    logic [1:0] bad_modes [2];

    tbl[0].mode_in  = 2'b01;
    tbl[0].restart  = 1'b0;
    tbl[0].exp_len  = 21;
    tbl[0].exp_mode = 2'b01;
    tbl[0].exp_lm   = {4'd2, 4'd1, 4'd0};
    tbl[0].exp_lt   = {4'd0, 4'd1, 4'd2};
    tbl[0].exp_i    = {10'd7, 10'd6, 10'd5, 10'd4, 10'd3, 10'd3, 10'd2, 10'd2,
                       10'd1, 10'd1, 10'd1, 10'd1};
    tbl[0].exp_we   = 12;

    tbl[1].mode_in  = 2'b10;
    tbl[1].restart  = 1'b0;
    tbl[1].exp_len  = 21;
    tbl[1].exp_mode = 2'b10;
    tbl[1].exp_lm   = {4'd0, 4'd1, 4'd2};
    tbl[1].exp_lt   = {4'd2, 4'd1, 4'd0};
    tbl[1].exp_i    = {10'd1, 10'd1, 10'd1, 10'd1, 10'd3, 10'd3, 10'd2, 10'd2,
                       10'd7, 10'd6, 10'd5, 10'd4};
    tbl[1].exp_we   = 12;

    tbl[2]          = tbl[0];
    tbl[2].restart  = 1'b1;

    bad_modes[0] = 2'b11;
    bad_modes[1] = 2'b00;

    rst_n   = 1'b0;
    start   = 1'b0;
    mode_in = 2'b00;
    #1;
    chk_all_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk_all_zero("idle_no_start");

    for (int k = 0; k < 3; k++) begin
      run_pass(tbl[k], $sformatf("pass%0d", k));
      repeat (2) @(negedge clk);
    end

    foreach (bad_modes[b]) begin
      start   = 1'b1;
      mode_in = bad_modes[b];
      @(negedge clk);
      start   = 1'b0;
      mode_in = 2'b00;
      chk($sformatf("bad_mode%0d_err", b), 32'(err), 32'd1);
      chk($sformatf("bad_mode%0d_busy", b), 32'(busy), 32'd0);
      @(negedge clk);
      chk($sformatf("bad_mode%0d_err_pulse", b), 32'(err), 32'd0);
      chk($sformatf("bad_mode%0d_still_idle", b), 32'(busy), 32'd0);
    end

    start   = 1'b1;
    mode_in = 2'b01;
    @(posedge clk);
    @(negedge clk);
    start   = 1'b0;
    mode_in = 2'b00;
    repeat (9) @(negedge clk);
    chk("midpass_stage1", 32'(log_m), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midpass_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done || busy) dcount++;
    end
    chk("midpass_no_done", 32'(dcount), 32'd0);

    run_pass(tbl[0], "after_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
